issue_scoreboard: RTL and testbench

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/issue_scoreboard.sv | 153 +++++++++++++++
 tb/tb_issue_scoreboard.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - single-entry RV32I issue stage with a per-register pending-write scoreboard
module issue_scoreboard (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instruction,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic        out_illegal,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        flush,
    output logic [31:0] busy_mask,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_instr;
    logic [31:0] r_busy;
    logic [31:0] w_busy_nxt;
    logic [15:0] r_stall;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic        w_uses_rs1;
    logic        w_uses_rs2;
    logic        w_uses_rd;
    logic        w_illegal;
    logic        w_hazard;
    logic        w_accept;
    logic        w_issue_fire;
    logic        w_stall;

    assign w_opcode = r_instr[6:0];
    assign w_rd     = r_instr[11:7];
    assign w_rs1    = r_instr[19:15];
    assign w_rs2    = r_instr[24:20];

    always_comb begin
        w_uses_rs1 = 1'b0;
        w_uses_rs2 = 1'b0;
        w_uses_rd  = 1'b0;
        w_illegal  = 1'b0;
        case (w_opcode)
            7'b0110011: begin
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
                w_uses_rd  = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                w_uses_rs1 = 1'b1;
                w_uses_rd  = 1'b1;
            end
            7'b0100011, 7'b1100011: begin
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
            end
            7'b0110111, 7'b0010111, 7'b1101111: begin
                w_uses_rd  = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // busy bit 0 is held at zero, so x0 operands can never raise a hazard
    assign w_hazard = (w_uses_rs1 && r_busy[w_rs1]) ||
                      (w_uses_rs2 && r_busy[w_rs2]) ||
                      (w_uses_rd  && r_busy[w_rd]);

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_issue_fire = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (!flush && in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    w_state_nxt = S_EMPTY;
                end else if (w_illegal || !w_hazard) begin
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            S_ISSUE: begin
                if (flush) begin
                    w_state_nxt = S_EMPTY;
                end else if (out_ready) begin
                    w_issue_fire = 1'b1;
                    w_state_nxt  = S_EMPTY;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // the issuing set is applied after the writeback clear so it wins on a collision
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_valid) begin
            w_busy_nxt[wb_rd] = 1'b0;
        end
        if (w_issue_fire && w_uses_rd) begin
            w_busy_nxt[w_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_EMPTY;
            r_instr <= '0;
            r_busy  <= '0;
            r_stall <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            if (w_accept) begin
                r_instr <= instruction;
            end else if (flush) begin
                r_instr <= '0;
            end
            if (w_stall && (r_stall != 16'hFFFF)) begin
                r_stall <= r_stall + 16'd1;
            end
        end
    end

    assign in_ready        = (r_state == S_EMPTY);
    assign out_valid       = (r_state == S_ISSUE);
    assign out_illegal     = out_valid && w_illegal;
    assign out_instruction = r_instr;
    assign busy_mask       = r_busy;
    assign stall_count     = r_stall;

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - directed vector bench for issue_scoreboard
module tb_issue_scoreboard;

    logic        CLK;
    logic        RST_N;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic        out_illegal;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [31:0] busy_mask;
    logic [15:0] stall_count;

    int n_cmp  = 0;
    int n_fail = 0;

    issue_scoreboard dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .instruction     (instruction),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_illegal     (out_illegal),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .flush           (flush),
        .busy_mask       (busy_mask),
        .stall_count     (stall_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic        exp_illegal;
        logic [31:0] exp_busy;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, output int lat);
        in_valid    = 1'b1;
        instruction = instr;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic wb_clear(input logic [4:0] rd);
        wb_valid = 1'b1;
        wb_rd    = rd;
        tick();
        wb_valid = 1'b0;
    endtask

    initial begin
        int lat;
        logic [15:0] s0;
        logic [15:0] s1;

        vecs[0] = '{32'h002081B3, 1'b0, 32'h0000_0008};
        vecs[1] = '{32'h0030A023, 1'b0, 32'h0000_0000};
        vecs[2] = '{32'h00000013, 1'b0, 32'h0000_0000};
        vecs[3] = '{32'h0000007F, 1'b1, 32'h0000_0000};
        vecs[4] = '{32'h00500293, 1'b0, 32'h0000_0020};
        vecs[5] = '{32'h12345537, 1'b0, 32'h0000_0400};
        vecs[6] = '{32'h00208463, 1'b0, 32'h0000_0000};
        vecs[7] = '{32'h008000EF, 1'b0, 32'h0000_0002};

        RST_N = 1'b0; in_valid = 1'b0; instruction = '0; out_ready = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
        repeat (2) tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instruction, 32'd0);
        chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
        chk("rst_busy", busy_mask, 32'd0);
        chk("rst_stall", {16'd0, stall_count}, 32'd0);
        RST_N = 1'b1;

        for (int i = 0; i < 8; i++) begin
            s0 = stall_count;
            issue(vecs[i].instr, lat);
            chk($sformatf("v%0d_latency", i), lat, 32'd2);
            chk($sformatf("v%0d_illegal", i), {31'd0, out_illegal}, {31'd0, vecs[i].exp_illegal});
            chk($sformatf("v%0d_instr", i), out_instruction, vecs[i].instr);
            consume();
            chk($sformatf("v%0d_out_valid_low", i), {31'd0, out_valid}, 32'd0);
            chk($sformatf("v%0d_busy", i), busy_mask, vecs[i].exp_busy);
            chk($sformatf("v%0d_no_stall", i), {16'd0, stall_count}, {16'd0, s0});
            if (vecs[i].exp_busy != 32'd0) begin
                wb_clear(vecs[i].instr[11:7]);
                chk($sformatf("v%0d_wb_clear", i), busy_mask, 32'd0);
            end
        end

        // RAW hazard on x3 held until writeback retires it
        issue(32'h002081B3, lat);
        consume();
        s0 = stall_count;
        in_valid = 1'b1; instruction = 32'h404182B3;
        tick();
        in_valid = 1'b0;
        repeat (2) @(posedge CLK);
        tick();
        chk("raw_stalled", {31'd0, out_valid}, 32'd0);
        chk("raw_stall_cnt3", {16'd0, stall_count}, {16'd0, s0 + 16'd3});
        wb_clear(5'd3);
        chk("raw_busy_cleared", busy_mask, 32'd0);
        chk("raw_still_wait", {31'd0, out_valid}, 32'd0);
        tick();
        chk("raw_issue", {31'd0, out_valid}, 32'd1);
        chk("raw_stall_cnt4", {16'd0, stall_count}, {16'd0, s0 + 16'd4});
        consume();
        chk("raw_busy_x5", busy_mask, 32'h0000_0020);
        wb_clear(5'd5);

        // illegal held with back-pressure
        issue(32'h0000007F, lat);
        chk("ill_latency", lat, 32'd2);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_instr", out_instruction, 32'h0000007F);
            chk("hold_illegal", {31'd0, out_illegal}, 32'd1);
        end
        consume();
        chk("ill_busy", busy_mask, 32'd0);

        // flush in WAIT beats a simultaneous in_valid
        issue(32'h002081B3, lat);
        consume();
        in_valid = 1'b1; instruction = 32'h404182B3;
        tick();
        in_valid = 1'b0;
        tick();
        s1 = stall_count;
        flush = 1'b1; in_valid = 1'b1; instruction = 32'h00000013;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_instr", out_instruction, 32'd0);
        chk("flush_stall", {16'd0, stall_count}, {16'd0, s1});
        chk("flush_busy", busy_mask, 32'h0000_0008);
        tick();
        chk("flush_idle", {31'd0, in_ready}, 32'd1);
        wb_clear(5'd3);

        // issue-set and writeback-clear of x7 on the same edge
        issue(32'h00700393, lat);
        out_ready = 1'b1; wb_valid = 1'b1; wb_rd = 5'd7;
        tick();
        out_ready = 1'b0; wb_valid = 1'b0;
        chk("same_edge_set_wins", busy_mask, 32'h0000_0080);

        // asynchronous reset while an instruction is offered
        issue(32'h002081B3, lat);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        RST_N = 1'b0;
        #2;
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_instr", out_instruction, 32'd0);
        chk("arst_illegal", {31'd0, out_illegal}, 32'd0);
        chk("arst_busy", busy_mask, 32'd0);
        chk("arst_stall", {16'd0, stall_count}, 32'd0);
        tick();
        RST_N = 1'b1;

        // stall counter saturation
        issue(32'h002081B3, lat);
        consume();
        in_valid = 1'b1; instruction = 32'h404182B3;
        tick();
        in_valid = 1'b0;
        repeat (70000) @(posedge CLK);
        #1;
        chk("stall_saturated", {16'd0, stall_count}, 32'h0000_FFFF);
        chk("sat_still_wait", {31'd0, out_valid}, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("sat_after_flush", {16'd0, stall_count}, 32'h0000_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
